// File: rtl/wave_mon_pkg.sv
// Shared types and defaults for the wave_monitor measurement block.
package wave_mon_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_FCNT_W = 24;
    localparam int MID_RESET  = 2048;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_LOW     = 2'd1,
        ST_HIGH    = 2'd2
    } schmitt_state_e;

endpackage

// File: rtl/schmitt_edge_detector.sv
// Schmitt-trigger state machine; flags a low-to-high crossing of hi_th in the
// same cycle as the sample that causes it.
module schmitt_edge_detector
    import wave_mon_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] hi_th,
    input  logic [DATA_W-1:0] lo_th,
    input  logic [DATA_W-1:0] mid,
    output logic              rise
);

    schmitt_state_e state, state_next;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_UNKNOWN;
        else     state <= state_next;
    end

    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and infers a latch.
    always_comb begin
        state_next = state;
        rise       = 1'b0;
        if (valid) begin
            case (state)
                ST_UNKNOWN: state_next = (sample >= mid) ? ST_HIGH : ST_LOW;
                ST_LOW: begin
                    if (sample >= hi_th) begin
                        state_next = ST_HIGH;
                        rise       = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (sample <= lo_th) state_next = ST_LOW;
                end
                default: state_next = ST_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/wave_monitor.sv
// Gated frequency / peak-to-peak measurement of a sample stream; results are
// latched once per gate window with a one-cycle result_valid strobe.
module wave_monitor
    import wave_mon_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int HYST        = 64,
    parameter int FCNT_W      = DEF_FCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [FCNT_W-1:0] freq_cnt,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic              no_signal,
    output logic              result_valid
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    logic [GATE_W-1:0] gate_cnt;
    logic              window_end;
    logic              s_valid_q;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] mid, hi_th, lo_th;
    logic [DATA_W:0]   hi_sum, mid_sum;
    logic              rise;
    logic [FCNT_W-1:0] edge_cnt, edge_next;
    logic              loaded, cur_loaded;
    logic [DATA_W-1:0] run_max, run_min, cur_max, cur_min;

    assign window_end = (gate_cnt == GATE_W'(GATE_CYCLES - 1));

    // Saturating thresholds around the midpoint.
    assign hi_sum = {1'b0, mid} + (DATA_W+1)'(HYST);
    assign hi_th  = (hi_sum > {1'b0, {DATA_W{1'b1}}}) ? {DATA_W{1'b1}} : hi_sum[DATA_W-1:0];
    assign lo_th  = ({1'b0, mid} >= (DATA_W+1)'(HYST)) ? (mid - DATA_W'(HYST)) : '0;

    schmitt_edge_detector #(.DATA_W(DATA_W)) u_schmitt (
        .clk    (clk),
        .rst    (rst),
        .valid  (s_valid_q),
        .sample (s_q),
        .hi_th  (hi_th),
        .lo_th  (lo_th),
        .mid    (mid),
        .rise   (rise)
    );

    // Running values including this cycle's registered sample, so the window
    // end sees its own last sample and crossing.
    always_comb begin
        edge_next  = (rise && (edge_cnt != {FCNT_W{1'b1}})) ? edge_cnt + FCNT_W'(1) : edge_cnt;
        cur_loaded = loaded | s_valid_q;
        cur_max    = run_max;
        cur_min    = run_min;
        if (s_valid_q) begin
            cur_max = (!loaded || (s_q > run_max)) ? s_q : run_max;
            cur_min = (!loaded || (s_q < run_min)) ? s_q : run_min;
        end
        mid_sum = {1'b0, cur_max} + {1'b0, cur_min};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_q <= 1'b0;
            s_q       <= '0;
        end else begin
            s_valid_q <= sample_valid;
            s_q       <= sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            loaded       <= 1'b0;
            run_max      <= '0;
            run_min      <= '0;
            mid          <= DATA_W'(MID_RESET);
            freq_cnt     <= '0;
            vmax         <= '0;
            vmin         <= '0;
            vpp          <= '0;
            no_signal    <= 1'b0;
            result_valid <= 1'b0;
        end else if (window_end) begin
            gate_cnt     <= '0;
            edge_cnt     <= '0;
            loaded       <= 1'b0;
            result_valid <= 1'b1;
            if (cur_loaded) begin
                freq_cnt  <= edge_next;
                vmax      <= cur_max;
                vmin      <= cur_min;
                vpp       <= cur_max - cur_min;
                no_signal <= 1'b0;
                mid       <= DATA_W'(mid_sum >> 1);
            end else begin
                freq_cnt  <= '0;
                vmax      <= '0;
                vmin      <= '0;
                vpp       <= '0;
                no_signal <= 1'b1;
            end
        end else begin
            gate_cnt     <= gate_cnt + GATE_W'(1);
            edge_cnt     <= edge_next;
            loaded       <= cur_loaded;
            run_max      <= cur_max;
            run_min      <= cur_min;
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_monitor.sv
// Directed bench for wave_monitor with a 1000-cycle gate window.
module tb_wave_monitor;

    localparam int GATE    = 1000;
    localparam int TIMEOUT = 1100;

    typedef enum int {
        M_IDLE, M_SQUARE, M_HYST_IN, M_HYST_OUT, M_CONST, M_TOGGLE, M_ZERO, M_BOUND
    } mode_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample;
    logic [23:0] freq_cnt;
    logic [11:0] vmax, vmin, vpp;
    logic        no_signal, result_valid;

    int    total = 0;
    int    bad   = 0;
    int    k     = 0;
    int    n;
    mode_e mode  = M_IDLE;

    wave_monitor #(.DATA_W(12), .GATE_CYCLES(GATE), .HYST(64), .FCNT_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .freq_cnt     (freq_cnt),
        .vmax         (vmax),
        .vmin         (vmin),
        .vpp          (vpp),
        .no_signal    (no_signal),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus (j = cycles since the last result strobe),
    // then advance to the next falling edge.
    task automatic drive(input int j);
        sample_valid = 1'b1;
        case (mode)
            M_IDLE:     begin sample_valid = 1'b0; sample = 12'hA5A; end
            M_SQUARE:   sample = (((k / 50) % 2) == 0) ? 12'd4095 : 12'd0;
            M_HYST_IN:  sample = (k % 2 == 0) ? 12'd2000 : 12'd2100;
            M_HYST_OUT: sample = (k % 2 == 0) ? 12'd1900 : 12'd2200;
            M_CONST:    sample = 12'd4095;
            M_TOGGLE:   sample = (k % 2 == 0) ? 12'd4000 : 12'd4095;
            M_ZERO:     sample = 12'd0;
            M_BOUND:    sample = (j == GATE - 2) ? 12'd4095 : 12'd0;
            default:    sample = 12'd0;
        endcase
        k++;
        @(negedge clk);
    endtask

    task automatic wait_result(output int cycles);
        cycles = -1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            drive(i - 1);
            if (result_valid) begin
                cycles = i;
                return;
            end
        end
        check("result_valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic settle(input mode_e m);
        int dummy;
        mode = m;
        wait_result(dummy);
        wait_result(dummy);
    endtask

    task automatic check_result(input string tag, input int f, input int mx, input int mn,
                                input int pp, input int ns);
        check({tag, "_freq"}, 32'(freq_cnt), 32'(f));
        check({tag, "_vmax"}, 32'(vmax), 32'(mx));
        check({tag, "_vmin"}, 32'(vmin), 32'(mn));
        check({tag, "_vpp"}, 32'(vpp), 32'(pp));
        check({tag, "_nosig"}, 32'(no_signal), 32'(ns));
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        repeat (3) @(negedge clk);
        check_result("reset", 0, 0, 0, 0, 0);
        check("reset_rv", 32'(result_valid), 32'(0));
        check("reset_mid", 32'(dut.mid), 32'(2048));
        rst = 1'b0;

        // First window with no input at all.
        mode = M_IDLE;
        wait_result(n);
        check("first_rv_latency", 32'(n), 32'(GATE));
        check_result("idle", 0, 0, 0, 0, 1);
        check("idle_mid", 32'(dut.mid), 32'(2048));

        // Square wave, 100-cycle period.
        settle(M_SQUARE);
        wait_result(n);
        check_result("square", 10, 4095, 0, 4095, 0);
        check("square_mid", 32'(dut.mid), 32'(2047));
        drive(0);
        check("square_rv_pulse", 32'(result_valid), 32'(0));

        // Reset in the middle of a window.
        repeat (498) drive(0);
        rst = 1'b1;
        @(negedge clk);
        check_result("midrst", 0, 0, 0, 0, 0);
        check("midrst_rv", 32'(result_valid), 32'(0));
        check("midrst_mid", 32'(dut.mid), 32'(2048));
        rst = 1'b0;
        wait_result(n);
        check("midrst_latency", 32'(n), 32'(GATE));

        // Swing inside the hysteresis band, then outside it.
        settle(M_HYST_IN);
        wait_result(n);
        check_result("hyst_in", 0, 2100, 2000, 100, 0);
        settle(M_HYST_OUT);
        wait_result(n);
        check_result("hyst_out", 500, 2200, 1900, 300, 0);

        // Full-scale constant, then a small toggle near full scale.
        settle(M_CONST);
        wait_result(n);
        check_result("const", 0, 4095, 4095, 0, 0);
        check("const_mid", 32'(dut.mid), 32'(4095));
        check("const_hi_th", 32'(dut.hi_th), 32'(4095));
        check("const_lo_th", 32'(dut.lo_th), 32'(4031));
        settle(M_TOGGLE);
        wait_result(n);
        check_result("toggle", 0, 4095, 4000, 95, 0);
        check("toggle_mid", 32'(dut.mid), 32'(4047));
        check("toggle_hi_th", 32'(dut.hi_th), 32'(4095));

        // Zero-level signal: thresholds clamp at the bottom.
        settle(M_ZERO);
        wait_result(n);
        check_result("zero", 0, 0, 0, 0, 0);
        check("zero_lo_th", 32'(dut.lo_th), 32'(0));
        check("zero_hi_th", 32'(dut.hi_th), 32'(64));

        // One crossing landing exactly on the window-end cycle.
        mode = M_BOUND;
        wait_result(n);
        check_result("bound", 1, 4095, 0, 4095, 0);
        mode = M_ZERO;
        wait_result(n);
        check_result("after_bound", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
